// File: rtl/window_assembler_pkg.sv
// Shared pixel/window definitions for the 9x9 neighbourhood preprocessing blocks.
package prep_pkg;
    localparam int PIX_W = 8;
    localparam int KSIZE = 9;
    localparam int KHALF = 4;

    typedef logic [PIX_W-1:0] pixel_t;

    // Bit offset of pixel (r, c) inside the flat window; r=0 top, c=0 left/oldest.
    function automatic int unsigned win_idx(input int unsigned r, input int unsigned c);
        return PIX_W * (KSIZE * r + c);
    endfunction
endpackage

// File: rtl/window_assembler_if.sv
// Tap-stream in / window-stream out bundle of the window assembler.
interface window_assembler_if #(
    parameter int IMG_W = 10,
    parameter int IMG_H = 10
);
    import prep_pkg::*;
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    logic                           valid_i;
    pixel_t                         row0_i, row1_i, row2_i, row3_i, row4_i;
    pixel_t                         row5_i, row6_i, row7_i, row8_i;
    logic [KSIZE*KSIZE*PIX_W-1:0]   window_o;
    logic                           valid_o;
    logic [RW-1:0]                  center_row_o;
    logic [CW-1:0]                  center_col_o;
    logic                           frame_done_o;

    modport master (
        output valid_i, row0_i, row1_i, row2_i, row3_i, row4_i,
               row5_i, row6_i, row7_i, row8_i,
        input  window_o, valid_o, center_row_o, center_col_o, frame_done_o
    );

    modport slave (
        input  valid_i, row0_i, row1_i, row2_i, row3_i, row4_i,
               row5_i, row6_i, row7_i, row8_i,
        output window_o, valid_o, center_row_o, center_col_o, frame_done_o
    );
endinterface

// File: rtl/window_assembler_shift.sv
// KSIZE x KSIZE pixel shift array: a new column enters on the right on each enabled cycle.
module window_shift_reg
    import prep_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_en,
    input  pixel_t                        i_col [KSIZE],
    output logic [KSIZE*KSIZE*PIX_W-1:0]  o_window
);
    pixel_t r_win [KSIZE][KSIZE];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned r = 0; r < KSIZE; r++)
                for (int unsigned c = 0; c < KSIZE; c++)
                    r_win[r][c] <= '0;
        end else if (i_en) begin
            for (int unsigned r = 0; r < KSIZE; r++) begin
                for (int unsigned c = 0; c < KSIZE-1; c++)
                    r_win[r][c] <= r_win[r][c+1];
                r_win[r][KSIZE-1] <= i_col[r];
            end
        end
    end

    always_comb begin
        o_window = '0;
        for (int unsigned r = 0; r < KSIZE; r++)
            for (int unsigned c = 0; c < KSIZE; c++)
                o_window[win_idx(r, c) +: PIX_W] = r_win[r][c];
    end
endmodule

// File: rtl/window_assembler.sv
// Shifts 9-row tap beats into a 9x9 window and flags windows lying fully inside the frame.
module window_assembler
    import prep_pkg::*;
#(
    parameter int IMG_W = 10,
    parameter int IMG_H = 10
) (
    input  logic                clk,
    input  logic                rst,
    window_assembler_if.slave   bus
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic          r_valid;
    logic          r_frame_done;
    logic [RW-1:0] r_center_row;
    logic [CW-1:0] r_center_col;
    pixel_t        w_col [KSIZE];
    logic          w_col_last;
    logic          w_row_last;
    logic          w_inside;

    // Window row 0 is the top (oldest line), so it takes the most-delayed tap.
    assign w_col[0] = bus.row8_i;
    assign w_col[1] = bus.row7_i;
    assign w_col[2] = bus.row6_i;
    assign w_col[3] = bus.row5_i;
    assign w_col[4] = bus.row4_i;
    assign w_col[5] = bus.row3_i;
    assign w_col[6] = bus.row2_i;
    assign w_col[7] = bus.row1_i;
    assign w_col[8] = bus.row0_i;

    assign w_col_last = (r_col == CW'(IMG_W-1));
    assign w_row_last = (r_row == RW'(IMG_H-1));
    assign w_inside   = (r_col >= CW'(KSIZE-1)) && (r_row >= RW'(KSIZE-1));

    window_shift_reg u_shift (
        .clk      (clk),
        .rst      (rst),
        .i_en     (bus.valid_i),
        .i_col    (w_col),
        .o_window (bus.window_o)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col        <= '0;
            r_row        <= '0;
            r_valid      <= 1'b0;
            r_frame_done <= 1'b0;
            r_center_row <= '0;
            r_center_col <= '0;
        end else if (bus.valid_i) begin
            r_valid      <= w_inside;
            r_frame_done <= w_col_last && w_row_last;
            if (w_inside) begin
                r_center_row <= r_row - RW'(KHALF);
                r_center_col <= r_col - CW'(KHALF);
            end
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end else begin
            r_valid      <= 1'b0;
            r_frame_done <= 1'b0;
        end
    end

    assign bus.valid_o      = r_valid;
    assign bus.frame_done_o = r_frame_done;
    assign bus.center_row_o = r_center_row;
    assign bus.center_col_o = r_center_col;
endmodule
